// File: rtl/ov7670_sccb_sequencer.sv
// Walks the camera register ROM and writes each entry to the OV7670 over SCCB
// as a three-phase write (device ID, register, value), honouring delay and end markers.
module ov7670_sccb_sequencer #(
    parameter int         CLK_FREQ_HZ  = 50000000,
    parameter int         SCCB_FREQ_HZ = 100000,
    parameter logic [7:0] CAM_ID       = 8'h42,
    parameter int         DELAY_CYCLES = 500000,
    parameter int         GAP_QUARTERS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resend,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        advance,
    output logic        config_done,
    output logic        busy,
    output logic        sioc,
    output logic        siod
);
    localparam int QTR            = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QW             = $clog2(QTR);
    localparam int SHIFT_QUARTERS = 27 * 4;
    localparam int STEP_MAX       = (GAP_QUARTERS > SHIFT_QUARTERS) ? GAP_QUARTERS : SHIFT_QUARTERS;
    localparam int SW             = $clog2(STEP_MAX);
    localparam int DW             = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [QW-1:0] QTR_LAST   = QW'(QTR - 1);
    localparam logic [SW-1:0] START_LAST = SW'(1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_QUARTERS - 1);
    localparam logic [SW-1:0] STOP_LAST  = SW'(2);
    localparam logic [SW-1:0] GAP_LAST   = SW'(GAP_QUARTERS - 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_FETCH, S_START, S_SHIFT,
        S_STOP, S_GAP, S_DELAY, S_ADV, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qtr_q, qtr_d;
    logic [SW-1:0]   step_q, step_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [26:0]     shift_q, shift_d;
    logic            sioc_q, sioc_d;
    logic            siod_q, siod_d;
    logic            tick;
    logic            timed;

    assign tick  = (qtr_q == QTR_LAST);
    assign timed = (state_q == S_START) || (state_q == S_SHIFT) ||
                   (state_q == S_STOP)  || (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        step_d  = step_q;
        dly_d   = dly_q;
        shift_d = shift_q;
        sioc_d  = 1'b1;
        siod_d  = 1'b1;

        if (timed) begin
            qtr_d = tick ? '0 : qtr_q + 1'b1;
        end

        case (state_q)
            S_IDLE:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_FETCH;
            S_FETCH: begin
                if (finished) begin
                    state_d = S_DONE;
                end else if (command == 16'hFFF0) begin
                    state_d = S_DELAY;
                end else begin
                    shift_d = {CAM_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
                    state_d = S_START;
                end
            end
            S_START: if (tick) begin
                step_d = step_q + 1'b1;
                if (step_q == START_LAST) state_d = S_SHIFT;
            end
            S_SHIFT: if (tick) begin
                step_d = step_q + 1'b1;
                // Next bit is presented at the end of each bit's last (high) quarter.
                if (step_q[1:0] == 2'b11) shift_d = {shift_q[25:0], 1'b0};
                if (step_q == SHIFT_LAST) state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                step_d = step_q + 1'b1;
                if (step_q == STOP_LAST) state_d = S_GAP;
            end
            S_GAP: if (tick) begin
                step_d = step_q + 1'b1;
                if (step_q == GAP_LAST) state_d = S_ADV;
            end
            S_DELAY: begin
                dly_d = dly_q + 1'b1;
                if (dly_q == DELAY_LAST) state_d = S_ADV;
            end
            S_ADV:   state_d = S_SETTLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (resend) begin
            state_d = S_SETTLE;
        end

        if (resend || (state_d != state_q)) begin
            qtr_d  = '0;
            step_d = '0;
            dly_d  = '0;
        end

        // Bus levels are registered alongside the state they belong to.
        case (state_d)
            S_START: begin
                sioc_d = (step_d == '0);
                siod_d = 1'b0;
            end
            S_SHIFT: begin
                sioc_d = step_d[1];
                siod_d = shift_d[26];
            end
            S_STOP: begin
                sioc_d = (step_d != '0);
                siod_d = (step_d == STOP_LAST);
            end
            default: begin
                sioc_d = 1'b1;
                siod_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            qtr_q   <= '0;
            step_q  <= '0;
            dly_q   <= '0;
            shift_q <= '0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            step_q  <= step_d;
            dly_q   <= dly_d;
            shift_q <= shift_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
        end
    end

    assign advance     = (state_q == S_ADV);
    assign config_done = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sioc        = sioc_q;
    assign siod        = siod_q;

endmodule
